// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter:
// register offsets, STATUS bit positions and FSM state encoding.
package uart_pkg;

    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;

    localparam int ST_BUSY   = 0;
    localparam int ST_FULL   = 1;
    localparam int ST_EMPTY  = 2;
    localparam int ST_OVF    = 3;
    localparam int ST_CNT_LO = 4;
    localparam int ST_PAR    = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } tx_state_e;

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Synchronous FIFO with first-word fall-through read port.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign count   = cnt_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_push && !do_pop)      cnt_d = cnt_q + CNT_W'(1);
        else if (do_pop && !do_push) cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA/STATUS registers, FIFO, 8N1 serializer.
// Define UART_PARITY_EN to insert an even-parity bit between data and stop.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          CLK_FREQ_HZ = 50_000_000,
    parameter int          BAUD        = 115_200,
    parameter int          FIFO_DEPTH  = 16
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [3:0]  MemWrite_EN,
    input  logic [31:0] MemAddr,
    input  logic [31:0] WriteData,
    output logic        sel_q,
    output logic [31:0] ReadData,
    output logic        uart_tx,
    output logic        irq_tx_empty
);
    localparam int DIV    = CLK_FREQ_HZ / BAUD;
    localparam int CW     = $clog2(DIV);
    localparam int CNTW   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

    tx_state_e   state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        ovf_q, ovf_d;
    logic        sel_d;
    logic [31:0] rdata_q, rdata_d;
    logic        irq_q, irq_d;
`ifdef UART_PARITY_EN
    logic        par_q, par_d;
`endif

    logic            hit, push, pop, ovf_clr, busy, baud_end;
    logic [1:0]      off;
    logic [7:0]      fifo_rdata;
    logic            fifo_full, fifo_empty;
    logic [CNTW-1:0] fifo_count;
    logic [3:0]      cnt4;
    logic [31:0]     status;
    logic            unused_ok;

    assign unused_ok = ^{MemAddr[11:4], MemAddr[1:0], WriteData[31:8]};

    assign hit     = (MemAddr[31:12] == BASE_ADDR[31:12]);
    assign off     = MemAddr[3:2];
    assign push    = hit & (off == OFF_TXDATA) & MemWrite_EN[0];
    assign ovf_clr = hit & (off == OFF_STATUS) & (|MemWrite_EN);
    assign busy    = (state_q != S_IDLE);
    assign cnt4    = 4'(fifo_count);

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .push  (push),
        .wdata (WriteData[7:0]),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        status                   = '0;
        status[ST_BUSY]          = busy;
        status[ST_FULL]          = fifo_full;
        status[ST_EMPTY]         = fifo_empty;
        status[ST_OVF]           = ovf_q;
        status[ST_CNT_LO +: 4]   = cnt4;
`ifdef UART_PARITY_EN
        status[ST_PAR]           = 1'b1;
`endif
        sel_d   = hit;
        rdata_d = (off == OFF_STATUS) ? status : 32'h0;
        ovf_d   = ovf_q;
        if (ovf_clr) ovf_d = 1'b0;
        if (push && fifo_full && !pop) ovf_d = 1'b1;
        irq_d   = fifo_empty & ~busy;
    end

    assign baud_end = (baud_q == DIV_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + CW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
`ifdef UART_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rdata;
                    bit_d   = 3'd0;
                    state_d = S_START;
`ifdef UART_PARITY_EN
                    par_d   = ^fifo_rdata;
`endif
                end
            end
            S_START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                baud_d  = '0;
                state_d = S_IDLE;
            end
        endcase

        // Line level follows the next state so uart_tx changes with the state flop.
        tx_d = 1'b1;
        if (state_d == S_START)     tx_d = 1'b0;
        else if (state_d == S_DATA) tx_d = shift_d[0];
`ifdef UART_PARITY_EN
        else if (state_d == S_PARITY) tx_d = par_q;
`endif
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
            sel_q   <= 1'b0;
            rdata_q <= '0;
            irq_q   <= 1'b1;
`ifdef UART_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
            sel_q   <= sel_d;
            rdata_q <= rdata_d;
            irq_q   <= irq_d;
`ifdef UART_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign ReadData     = rdata_q;
    assign uart_tx      = tx_q;
    assign irq_tx_empty = irq_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed self-checking bench for mmio_uart_tx (DIV=10).
// Decodes the serial line at bit centres and checks register reads.
module tb_mmio_uart_tx;

    localparam int DIV = 10;
`ifdef UART_PARITY_EN
    localparam int          NBITS = 11;
    localparam logic [31:0] PARB  = 32'h100;
`else
    localparam int          NBITS = 10;
    localparam logic [31:0] PARB  = 32'h0;
`endif
    localparam logic [31:0] A_TX = 32'h1000_0000;
    localparam logic [31:0] A_ST = 32'h1000_0004;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  we = 4'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        sel;
    logic [31:0] rdata;
    logic        tx;
    logic        irq;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    mmio_uart_tx #(
        .BASE_ADDR   (32'h1000_0000),
        .CLK_FREQ_HZ (1_000_000),
        .BAUD        (100_000),
        .FIFO_DEPTH  (16)
    ) dut (
        .sys_clk      (clk),
        .sys_rst_n    (rst_n),
        .MemWrite_EN  (we),
        .MemAddr      (addr),
        .WriteData    (wdata),
        .sel_q        (sel),
        .ReadData     (rdata),
        .uart_tx      (tx),
        .irq_tx_empty (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] e);
        @(negedge clk);
        addr  = a;
        wdata = d;
        we    = e;
    endtask

    task automatic bus_idle();
        @(negedge clk);
        we   = 4'h0;
        addr = 32'h0;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d,
                          output logic s);
        @(negedge clk);
        addr = a;
        we   = 4'h0;
        @(negedge clk);
        d = rdata;
        s = sel;
    endtask

    task automatic rx_frame(output logic [7:0] d, output int t0,
                            output logic p);
        int n;
        n  = 0;
        d  = 8'h0;
        p  = 1'b0;
        while (tx !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("rx_start_seen", {31'b0, tx}, 32'h0);
        t0 = cyc;
        repeat (DIV / 2) @(negedge clk);
        check("rx_start_mid", {31'b0, tx}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            repeat (DIV) @(negedge clk);
            d[i] = tx;
        end
`ifdef UART_PARITY_EN
        repeat (DIV) @(negedge clk);
        p = tx;
        check("rx_parity", {31'b0, p}, {31'b0, ^d});
`endif
        repeat (DIV) @(negedge clk);
        check("rx_stop", {31'b0, tx}, 32'h1);
    endtask

    function automatic logic [7:0] pat(input int i);
        return 8'(i * 37 + 5);
    endfunction

    logic [31:0] rv;
    logic        rs;
    logic [7:0]  rxb;
    int          rxt;
    logic        rxp;
    logic [7:0]  fb;
    int          ft;
    logic        fp;
    logic [7:0]  got_b [17];
    int          got_t [17];
    int          lows;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx", {31'b0, tx}, 32'h1);
        check("rst_irq", {31'b0, irq}, 32'h1);
        check("rst_rdata", rdata, 32'h0);
        check("rst_sel", {31'b0, sel}, 32'h0);
        rst_n = 1'b1;

        // 1: idle status
        bus_rd(A_ST, rv, rs);
        check("t1_status", rv, 32'h04 | PARB);
        check("t1_sel", {31'b0, rs}, 32'h1);
        bus_rd(32'h0000_0004, rv, rs);
        check("t1_sel_miss", {31'b0, rs}, 32'h0);
        check("t1_tx_idle", {31'b0, tx}, 32'h1);

        // 2: single frame 0x55
        bus_wr(A_TX, 32'h55, 4'h1);
        bus_idle();
        rx_frame(rxb, rxt, rxp);
        check("t2_data", {24'b0, rxb}, 32'h55);
        repeat (DIV) @(negedge clk);
        check("t2_irq", {31'b0, irq}, 32'h1);
        bus_rd(A_ST, rv, rs);
        check("t2_status", rv, 32'h04 | PARB);

        // 3: fill FIFO, overflow, drain in order
        fork
            begin
                for (int i = 0; i < 17; i++) begin
                    rx_frame(fb, ft, fp);
                    got_b[i] = fb;
                    got_t[i] = ft;
                end
            end
            begin
                for (int i = 0; i < 17; i++) bus_wr(A_TX, {24'b0, pat(i)}, 4'hF);
                bus_idle();
                bus_rd(A_ST, rv, rs);
                check("t3_full", rv, 32'h03 | PARB);
                bus_wr(A_TX, 32'hEE, 4'h1);
                bus_idle();
                bus_rd(A_ST, rv, rs);
                check("t3_ovf", rv, 32'h0B | PARB);
                bus_wr(A_ST, 32'h0, 4'hF);
                bus_idle();
                bus_rd(A_ST, rv, rs);
                check("t3_ovf_clr", rv, 32'h03 | PARB);
                bus_rd(A_TX, rv, rs);
                check("t3_txdata_rd", rv, 32'h0);
            end
        join
        for (int i = 0; i < 17; i++) begin
            check($sformatf("t3_frame%0d", i), {24'b0, got_b[i]}, {24'b0, pat(i)});
            if (i > 0)
                check($sformatf("t3_gap%0d", i), 32'(got_t[i] - got_t[i-1]),
                      32'(NBITS * DIV + 1));
        end
        repeat (2 * DIV) @(negedge clk);
        check("t3_irq", {31'b0, irq}, 32'h1);

        // 4: ignored stores
        bus_wr(A_TX, 32'h11, 4'b0010);
        bus_wr(32'h1000_0008, 32'h22, 4'hF);
        bus_idle();
        bus_rd(A_ST, rv, rs);
        check("t4_status", rv, 32'h04 | PARB);
        bus_rd(32'h1000_000C, rv, rs);
        check("t4_off3_rd", rv, 32'h0);
        lows = 0;
        repeat (30) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check("t4_no_frame", 32'(lows), 32'h0);

        // 5: async reset in DATA bit 3 of 0xA5
        bus_wr(A_TX, 32'hA5, 4'h1);
        bus_wr(A_TX, 32'h5A, 4'h1);
        bus_idle();
        lows = 0;
        while (tx !== 1'b0 && lows < 400) begin
            @(negedge clk);
            lows++;
        end
        repeat (DIV / 2 + 4 * DIV) @(negedge clk);
        check("t5_bit3", {31'b0, tx}, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_tx", {31'b0, tx}, 32'h1);
        check("t5_async_irq", {31'b0, irq}, 32'h1);
        check("t5_async_rdata", rdata, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bus_rd(A_ST, rv, rs);
        check("t5_status", rv, 32'h04 | PARB);
        lows = 0;
        repeat (150) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check("t5_no_residual", 32'(lows), 32'h0);
        bus_wr(A_TX, 32'h3C, 4'h1);
        bus_idle();
        rx_frame(rxb, rxt, rxp);
        check("t5_clean", {24'b0, rxb}, 32'h3C);

        // 6: parity frame 0x07
        bus_wr(A_TX, 32'h07, 4'h1);
        bus_wr(A_TX, 32'h07, 4'h1);
        bus_idle();
        rx_frame(rxb, rxt, rxp);
        check("t6_data0", {24'b0, rxb}, 32'h07);
        ft = rxt;
        rx_frame(rxb, rxt, rxp);
        check("t6_data1", {24'b0, rxb}, 32'h07);
        check("t6_period", 32'(rxt - ft), 32'(NBITS * DIV + 1));
`ifdef UART_PARITY_EN
        check("t6_parity", {31'b0, rxp}, 32'h1);
`endif
        repeat (2 * DIV) @(negedge clk);
        bus_rd(A_ST, rv, rs);
        check("t6_status", rv, 32'h04 | PARB);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
